cc_set_ctrl: RTL and testbench

- Front-panel controller for the custom BCD clock counter: runs the set-time and set-alarm state machine from the panel buttons.
- Issues a one-cycle time load to the counter, holds the alarm time and enable, and drives the alarm LED by comparing the live counter digits against the alarm.
- Sits between the debounced panel buttons and the clock counter.
- Runs in the 1 Hz clock domain.

---
 rtl/cc_set_ctrl.sv | 178 +++++++++++++++++
 tb/tb_cc_set_ctrl.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cc_set_ctrl.sv
// Front-panel controller for the BCD clock: set-time / set-alarm state machine,
// stored alarm time and enable, and the alarm LED ring timer.
module cc_set_ctrl #(
    parameter int RING_LEN = 60
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_mode,
    input  logic       btn_next,
    input  logic       btn_inc,
    input  logic       btn_stop,
    input  logic [1:0] cur_ht,
    input  logic [3:0] cur_ho,
    input  logic [2:0] cur_mt,
    input  logic [3:0] cur_mo,
    input  logic [2:0] cur_st,
    input  logic [3:0] cur_so,
    output logic [1:0] set_ht,
    output logic [3:0] set_ho,
    output logic [2:0] set_mt,
    output logic [3:0] set_mo,
    output logic [2:0] set_st,
    output logic [3:0] set_so,
    output logic       set_load,
    output logic [1:0] alm_ht,
    output logic [3:0] alm_ho,
    output logic [2:0] alm_mt,
    output logic [3:0] alm_mo,
    output logic       alarm_en,
    output logic [1:0] edit_mode,
    output logic [1:0] edit_field,
    output logic       led_alarm
);

    typedef enum logic [2:0] {
        ST_RUN, ST_TH, ST_TM, ST_TS, ST_AH, ST_AM, ST_AEN
    } state_t;

    localparam logic [7:0] RING_LOAD = 8'(RING_LEN);

    state_t     state_r;
    logic       mode_q_r, next_q_r, inc_q_r, stop_q_r;
    logic [7:0] ring_r;
    logic       mode_press_s, next_press_s, inc_press_s, stop_press_s;
    logic       match_s;

    // Hours field 00..23 in BCD, wrapping to 00.
    function automatic logic [5:0] inc_hours(input logic [1:0] t, input logic [3:0] o);
        logic [5:0] r;
        if (t == 2'd2 && o == 4'd3) r = 6'd0;
        else if (o == 4'd9)         r = {t + 2'd1, 4'd0};
        else                        r = {t, o + 4'd1};
        return r;
    endfunction

    // Minutes/seconds field 00..59 in BCD, wrapping to 00.
    function automatic logic [6:0] inc_sexa(input logic [2:0] t, input logic [3:0] o);
        logic [6:0] r;
        if (t == 3'd5 && o == 4'd9) r = 7'd0;
        else if (o == 4'd9)         r = {t + 3'd1, 4'd0};
        else                        r = {t, o + 4'd1};
        return r;
    endfunction

    // Edge detection; stop is outside the mode > next > inc priority chain.
    always_comb begin
        mode_press_s = btn_mode & ~mode_q_r;
        next_press_s = btn_next & ~next_q_r;
        inc_press_s  = btn_inc  & ~inc_q_r;
        stop_press_s = btn_stop & ~stop_q_r;
        match_s      = (state_r == ST_RUN) && alarm_en &&
                       (cur_ht == alm_ht) && (cur_ho == alm_ho) &&
                       (cur_mt == alm_mt) && (cur_mo == alm_mo) &&
                       (cur_st == 3'd0) && (cur_so == 4'd0);
    end

    // Panel state machine with registered edit outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= ST_RUN;
            mode_q_r   <= 1'b0;
            next_q_r   <= 1'b0;
            inc_q_r    <= 1'b0;
            stop_q_r   <= 1'b0;
            {set_ht, set_ho, set_mt, set_mo, set_st, set_so} <= 20'd0;
            {alm_ht, alm_ho, alm_mt, alm_mo} <= 13'd0;
            alarm_en   <= 1'b0;
            set_load   <= 1'b0;
            edit_mode  <= 2'd0;
            edit_field <= 2'd0;
        end else begin
            mode_q_r <= btn_mode;
            next_q_r <= btn_next;
            inc_q_r  <= btn_inc;
            stop_q_r <= btn_stop;
            set_load <= 1'b0;
            case (state_r)
                ST_RUN: begin
                    if (mode_press_s) begin
                        {set_ht, set_ho, set_mt, set_mo, set_st, set_so} <=
                            {cur_ht, cur_ho, cur_mt, cur_mo, cur_st, cur_so};
                        state_r    <= ST_TH;
                        edit_mode  <= 2'd1;
                        edit_field <= 2'd0;
                    end
                end
                ST_TH, ST_TM, ST_TS: begin
                    if (mode_press_s) begin
                        state_r    <= ST_AH;
                        set_load   <= 1'b1;
                        edit_mode  <= 2'd2;
                        edit_field <= 2'd0;
                    end else if (next_press_s) begin
                        case (state_r)
                            ST_TH:   begin state_r <= ST_TM; edit_field <= 2'd1; end
                            ST_TM:   begin state_r <= ST_TS; edit_field <= 2'd2; end
                            default: begin state_r <= ST_TH; edit_field <= 2'd0; end
                        endcase
                    end else if (inc_press_s) begin
                        case (state_r)
                            ST_TH:   {set_ht, set_ho} <= inc_hours(set_ht, set_ho);
                            ST_TM:   {set_mt, set_mo} <= inc_sexa(set_mt, set_mo);
                            default: {set_st, set_so} <= inc_sexa(set_st, set_so);
                        endcase
                    end
                end
                ST_AH, ST_AM: begin
                    if (mode_press_s) begin
                        state_r    <= ST_AEN;
                        edit_mode  <= 2'd3;
                        edit_field <= 2'd0;
                    end else if (next_press_s) begin
                        state_r    <= (state_r == ST_AH) ? ST_AM : ST_AH;
                        edit_field <= (state_r == ST_AH) ? 2'd1 : 2'd0;
                    end else if (inc_press_s) begin
                        if (state_r == ST_AH) {alm_ht, alm_ho} <= inc_hours(alm_ht, alm_ho);
                        else                  {alm_mt, alm_mo} <= inc_sexa(alm_mt, alm_mo);
                    end
                end
                ST_AEN: begin
                    if (mode_press_s) begin
                        state_r    <= ST_RUN;
                        edit_mode  <= 2'd0;
                        edit_field <= 2'd0;
                    end else if (inc_press_s) begin
                        alarm_en <= ~alarm_en;
                    end
                end
                default: begin
                    state_r    <= ST_RUN;
                    edit_mode  <= 2'd0;
                    edit_field <= 2'd0;
                end
            endcase
        end
    end

    // Ring timer: stop, leaving RUN or a disarmed alarm silence it before a match reloads it.
    always_ff @(posedge clk) begin
        if (reset) begin
            ring_r    <= 8'd0;
            led_alarm <= 1'b0;
        end else if (stop_press_s || (state_r != ST_RUN) || mode_press_s || !alarm_en) begin
            ring_r    <= 8'd0;
            led_alarm <= 1'b0;
        end else if (match_s) begin
            ring_r    <= RING_LOAD;
            led_alarm <= (RING_LOAD != 8'd0);
        end else if (ring_r != 8'd0) begin
            ring_r    <= ring_r - 8'd1;
            led_alarm <= (ring_r != 8'd1);
        end else begin
            ring_r    <= 8'd0;
            led_alarm <= 1'b0;
        end
    end

endmodule

// File: tb/tb_cc_set_ctrl.sv
// Scoreboard bench for cc_set_ctrl: expectations are queued as stimulus is
// applied and compared against the outputs sampled one time unit after the edge.
module tb_cc_set_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       btn_mode, btn_next, btn_inc, btn_stop;
    logic [1:0] cur_ht;
    logic [3:0] cur_ho;
    logic [2:0] cur_mt;
    logic [3:0] cur_mo;
    logic [2:0] cur_st;
    logic [3:0] cur_so;
    logic [1:0] set_ht;
    logic [3:0] set_ho;
    logic [2:0] set_mt;
    logic [3:0] set_mo;
    logic [2:0] set_st;
    logic [3:0] set_so;
    logic       set_load;
    logic [1:0] alm_ht;
    logic [3:0] alm_ho;
    logic [2:0] alm_mt;
    logic [3:0] alm_mo;
    logic       alarm_en;
    logic [1:0] edit_mode;
    logic [1:0] edit_field;
    logic       led_alarm;

    int checks = 0;
    int errors = 0;
    int load_cnt = 0;

    typedef struct {
        string       tag;
        logic [31:0] exp;
    } sb_t;
    sb_t sb_q[$];

    cc_set_ctrl #(.RING_LEN(60)) dut (
        .clk(clk), .reset(reset),
        .btn_mode(btn_mode), .btn_next(btn_next), .btn_inc(btn_inc), .btn_stop(btn_stop),
        .cur_ht(cur_ht), .cur_ho(cur_ho), .cur_mt(cur_mt), .cur_mo(cur_mo),
        .cur_st(cur_st), .cur_so(cur_so),
        .set_ht(set_ht), .set_ho(set_ho), .set_mt(set_mt), .set_mo(set_mo),
        .set_st(set_st), .set_so(set_so), .set_load(set_load),
        .alm_ht(alm_ht), .alm_ho(alm_ho), .alm_mt(alm_mt), .alm_mo(alm_mo),
        .alarm_en(alarm_en), .edit_mode(edit_mode), .edit_field(edit_field),
        .led_alarm(led_alarm)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (set_load) load_cnt++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic sb_push(input string tag, input logic [31:0] exp);
        sb_t e;
        e.tag = tag;
        e.exp = exp;
        sb_q.push_back(e);
    endtask

    task automatic sb_pop(input logic [31:0] obs);
        sb_t e;
        if (sb_q.size() == 0) begin
            chk("sb_underflow", 32'(sb_q.size()), 32'd1);
        end else begin
            e = sb_q.pop_front();
            chk(e.tag, obs, e.exp);
        end
    endtask

    function automatic logic [19:0] mk_t(input int h, input int m, input int s);
        logic [1:0] a; logic [3:0] b; logic [2:0] c; logic [3:0] d; logic [2:0] e; logic [3:0] f;
        a = 2'(h / 10); b = 4'(h % 10);
        c = 3'(m / 10); d = 4'(m % 10);
        e = 3'(s / 10); f = 4'(s % 10);
        return {a, b, c, d, e, f};
    endfunction

    function automatic logic [12:0] mk_a(input int h, input int m);
        logic [19:0] t;
        t = mk_t(h, m, 0);
        return t[19:7];
    endfunction

    function automatic logic [19:0] set_now();
        return {set_ht, set_ho, set_mt, set_mo, set_st, set_so};
    endfunction

    function automatic logic [12:0] alm_now();
        return {alm_ht, alm_ho, alm_mt, alm_mo};
    endfunction

    task automatic set_cur(input int h, input int m, input int s);
        {cur_ht, cur_ho, cur_mt, cur_mo, cur_st, cur_so} = mk_t(h, m, s);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // 0 = mode, 1 = next, 2 = inc, 3 = stop
    task automatic press(input int which);
        case (which)
            0: btn_mode = 1'b1;
            1: btn_next = 1'b1;
            2: btn_inc  = 1'b1;
            default: btn_stop = 1'b1;
        endcase
        tick();
        {btn_mode, btn_next, btn_inc, btn_stop} = 4'b0000;
        tick();
    endtask

    initial begin
        int n;
        reset = 1'b1;
        {btn_mode, btn_next, btn_inc, btn_stop} = 4'b0000;
        set_cur(0, 0, 0);
        tick();
        reset = 1'b0;
        tick();

        sb_push("rst_mode", 32'd0);
        sb_push("rst_load", 32'd0);
        sb_push("rst_led", 32'd0);
        sb_push("rst_alm", 32'(mk_a(0, 0)));
        sb_push("rst_en", 32'd0);
        sb_push("rst_set", 32'(mk_t(0, 0, 0)));
        sb_pop(32'(edit_mode));
        sb_pop(32'(set_load));
        sb_pop(32'(led_alarm));
        sb_pop(32'(alm_now()));
        sb_pop(32'(alarm_en));
        sb_pop(32'(set_now()));

        // Edit seconds of 12:34:56 and commit
        set_cur(12, 34, 56);
        press(0);
        sb_push("copy_cur", 32'(mk_t(12, 34, 56)));
        sb_pop(32'(set_now()));
        press(1);
        press(1);
        sb_push("field_sec", 32'd2);
        sb_pop(32'(edit_field));
        press(2);
        load_cnt = 0;
        btn_mode = 1'b1;
        tick();
        btn_mode = 1'b0;
        sb_push("load_first_ah", 32'd1);
        sb_push("mode_ah", 32'd2);
        sb_push("set_commit", 32'(mk_t(12, 34, 57)));
        sb_pop(32'(set_load));
        sb_pop(32'(edit_mode));
        sb_pop(32'(set_now()));
        tick();
        tick();
        sb_push("load_count", 32'd1);
        sb_pop(32'(load_cnt));

        // Wrap checks from 23:59:59
        press(0);
        press(0);
        set_cur(23, 59, 59);
        press(0);
        press(2);
        sb_push("hour_wrap", 32'(mk_t(0, 59, 59)));
        sb_pop(32'(set_now()));
        press(1);
        press(2);
        sb_push("min_wrap", 32'(mk_t(0, 0, 59)));
        sb_pop(32'(set_now()));
        press(1);
        press(2);
        sb_push("sec_wrap", 32'(mk_t(0, 0, 0)));
        sb_pop(32'(set_now()));
        set_cur(9, 0, 0);
        press(0);
        press(0);
        press(0);
        press(0);
        press(2);
        sb_push("hour_09_10", 32'(mk_t(10, 0, 0)));
        sb_pop(32'(set_now()));

        // Arm alarm at 01:00
        press(0);
        press(2);
        sb_push("alm_0100", 32'(mk_a(1, 0)));
        sb_pop(32'(alm_now()));
        set_cur(0, 59, 59);
        press(0);
        sb_push("mode_en", 32'd3);
        sb_pop(32'(edit_mode));
        press(2);
        press(0);
        sb_push("armed", 32'd1);
        sb_push("back_run", 32'd0);
        sb_push("led_pre", 32'd0);
        sb_pop(32'(alarm_en));
        sb_pop(32'(edit_mode));
        sb_pop(32'(led_alarm));

        // Match, ring length
        set_cur(1, 0, 0);
        tick();
        set_cur(1, 0, 1);
        n = 0;
        while (led_alarm && n < 200) begin
            n++;
            tick();
        end
        sb_push("ring_len", 32'd60);
        sb_pop(32'(n));
        tick();
        tick();
        sb_push("no_ring_0001", 32'd0);
        sb_pop(32'(led_alarm));

        // Stop silences
        set_cur(1, 0, 0);
        tick();
        set_cur(1, 0, 1);
        sb_push("ring_again", 32'd1);
        sb_pop(32'(led_alarm));
        tick();
        btn_stop = 1'b1;
        tick();
        btn_stop = 1'b0;
        sb_push("stop_led", 32'd0);
        sb_pop(32'(led_alarm));
        tick();

        // Mode silences and enters edit
        set_cur(1, 0, 0);
        tick();
        set_cur(1, 0, 1);
        sb_push("ring_third", 32'd1);
        sb_pop(32'(led_alarm));
        btn_mode = 1'b1;
        tick();
        btn_mode = 1'b0;
        sb_push("mode_led", 32'd0);
        sb_push("mode_edit", 32'd1);
        sb_pop(32'(led_alarm));
        sb_pop(32'(edit_mode));
        tick();

        // Disarm, matching time must not ring
        press(0);
        press(0);
        press(2);
        press(0);
        sb_push("disarmed", 32'd0);
        sb_pop(32'(alarm_en));
        set_cur(1, 0, 0);
        tick();
        tick();
        sb_push("no_ring_dis", 32'd0);
        sb_pop(32'(led_alarm));

        // Mode and inc together in T_M
        press(0);
        press(1);
        btn_mode = 1'b1;
        btn_inc  = 1'b1;
        tick();
        {btn_mode, btn_inc} = 2'b00;
        sb_push("coinc_mode", 32'd2);
        sb_push("coinc_min", 32'(mk_t(1, 0, 0)));
        sb_pop(32'(edit_mode));
        sb_pop(32'(set_now()));
        tick();

        // Held inc counts once
        btn_inc = 1'b1;
        repeat (5) tick();
        btn_inc = 1'b0;
        tick();
        sb_push("held_inc", 32'(mk_a(2, 0)));
        sb_pop(32'(alm_now()));

        chk("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
